// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
// Receives a boot image over a byte stream (valid/ready handshake) and writes
// it into the instruction memory one word at a time. The first byte of a load
// is a header that gives the word count L. After the header come L words of
// N/8 bytes each, most significant byte first. The processor is held in reset
// until a load completes cleanly.
//
// Ports
//   clk_i         rising-edge clock
//   reset_i       asynchronous active-high reset
//   start_i       begin a new load (honoured only in IDLE, DONE or ERR)
//   rx_data_i     incoming byte
//   rx_valid_i    rx_data_i holds a byte
//   rx_ready_o    loader accepts a byte this cycle (HDR and BYTE only)
//   wr_en_o       IMEM write strobe, one cycle per word
//   wr_addr_o     IMEM word address
//   wr_data_o     assembled instruction word
//   cpu_hold_o    keeps the CPU in reset whenever the loader is not in DONE
//   busy_o        load in progress (HDR, BYTE, WRITE)
//   done_o        load completed
//   err_o         header was out of range
//   word_count_o  words written so far in the current load
// -----------------------------------------------------------------------------
module imem_loader #(
  parameter int N    = 32,
  parameter int MAXW = 64,
  localparam int AW  = $clog2(MAXW),
  localparam int CW  = $clog2(MAXW + 1)
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          start_i,
  input  logic [7:0]    rx_data_i,
  input  logic          rx_valid_i,
  output logic          rx_ready_o,
  output logic          wr_en_o,
  output logic [AW-1:0] wr_addr_o,
  output logic [N-1:0]  wr_data_o,
  output logic          cpu_hold_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o,
  output logic [CW-1:0] word_count_o
);

  localparam int BPW = N / 8;
  localparam int BW  = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [BW-1:0] LAST_BYTE = BW'(BPW - 1);

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    BYTE,
    WRITE,
    DONE,
    ERR
  } state_e;

  state_e        state_q, state_d;
  logic [BW-1:0] byte_cnt_q, byte_cnt_d;
  logic [CW-1:0] word_cnt_q, word_cnt_d;
  logic [CW-1:0] len_q, len_d;
  logic [N-1:0]  asm_q, asm_d;
  logic [CW-1:0] word_cnt_inc;

  assign word_cnt_inc = word_cnt_q + CW'(1);

  // State and datapath registers. Reset clears everything, so a load cut
  // short by reset never produces a write strobe for its partial word.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      byte_cnt_q <= '0;
      word_cnt_q <= '0;
      len_q      <= '0;
      asm_q      <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      word_cnt_q <= word_cnt_d;
      len_q      <= len_d;
      asm_q      <= asm_d;
    end
  end

  // Next-state and datapath update. Bytes are consumed only in HDR and BYTE,
  // and only when rx_valid_i is high, because rx_ready_o is high in exactly
  // those states. Any gap in rx_valid_i therefore leaves all state untouched.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    word_cnt_d = word_cnt_q;
    len_d      = len_q;
    asm_d      = asm_q;
    unique case (state_q)
      IDLE, DONE, ERR: begin
        if (start_i) begin
          state_d    = HDR;
          byte_cnt_d = '0;
          word_cnt_d = '0;
          asm_d      = '0;
        end
      end
      HDR: begin
        if (rx_valid_i) begin
          if (rx_data_i == 8'd0 || int'(rx_data_i) > MAXW) begin
            state_d = ERR;
          end else begin
            len_d   = CW'(rx_data_i);
            state_d = BYTE;
          end
        end
      end
      BYTE: begin
        if (rx_valid_i) begin
          // Shift in MSB-first: the first byte ends up in the top byte lane.
          asm_d      = (asm_q << 8) | N'(rx_data_i);
          byte_cnt_d = byte_cnt_q + BW'(1);
          if (byte_cnt_q == LAST_BYTE) begin
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        word_cnt_d = word_cnt_inc;
        byte_cnt_d = '0;
        state_d    = (word_cnt_inc == len_q) ? DONE : BYTE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the registered state only. The write address
  // comes straight from the word counter, which never exceeds L-1 <= MAXW-1
  // while in WRITE.
  always_comb begin
    rx_ready_o   = 1'b0;
    wr_en_o      = 1'b0;
    busy_o       = 1'b0;
    done_o       = 1'b0;
    err_o        = 1'b0;
    cpu_hold_o   = 1'b1;
    wr_addr_o    = word_cnt_q[AW-1:0];
    wr_data_o    = asm_q;
    word_count_o = word_cnt_q;
    unique case (state_q)
      HDR, BYTE: begin
        rx_ready_o = 1'b1;
        busy_o     = 1'b1;
      end
      WRITE: begin
        wr_en_o = 1'b1;
        busy_o  = 1'b1;
      end
      DONE: begin
        done_o     = 1'b1;
        cpu_hold_o = 1'b0;
      end
      ERR: begin
        err_o = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule
